mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-ported, 16-bit multicycle main memory (single-cycle write, 4-cycle pipelined read) between the I-cache fill engine and the D-cache fill/write-through engine.
- Converts a block-read request into 8 back-to-back pipelined word reads, then returns the words in order with a word index.
- Passes single-word writes through in one cycle.
- Is the only driver of the memory's enable/wr/addr/data_in pins.

Parameters:
- ADDR_WIDTH, 16, byte-address width shared with memory.
- BLOCK_WORDS, 8, words per cache block; power of 2.
- MEM_LAT, 4, memory read latency in cycles from enable to data_valid.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-cache block-read request; held until i_done
- i_addr  in  ADDR_WIDTH  I-cache miss byte address
- i_grant  out  1  I-cache transaction in progress
- i_data  out  16  returned read word
- i_data_valid  out  1  i_data valid this cycle
- i_word  out  log2(BLOCK_WORDS)  index of i_data within block
- i_done  out  1  one-cycle pulse, block complete
- d_req  in  1  D-cache request; held until d_done
- d_wr  in  1  1 = single-word write, 0 = block read
- d_addr  in  ADDR_WIDTH  D-cache byte address
- d_wdata  in  16  write data
- d_grant, d_data, d_data_valid, d_word, d_done  out  1/16/1/log2(BLOCK_WORDS)/1  same meaning as I-side
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  memory read-data valid

Behaviour:
- Reset: all outputs 0; state FLUSH; flush counter = MEM_LAT.
- FLUSH: drops stale memory returns. Counts down one per cycle. Enters IDLE when the counter reaches 0. No grants are issued in FLUSH.
- IDLE:
  - Samples requests each cycle. Requests decided in IDLE cycle t start in cycle t+1.
  - Priority: D over I (see optional feature).
  - d_req & d_wr -> WRITE.
  - d_req & ~d_wr, or the I-side winning -> ISSUE. Latch the owner, and latch the base address with low log2(BLOCK_WORDS)+1 bits forced to 0.
- WRITE (1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr = d_addr with bit0 forced to 0, mem_data_in = d_wdata.
  - d_grant=1 and d_done=1 in this cycle. Next state IDLE.
- ISSUE (BLOCK_WORDS cycles):
  - mem_enable=1, mem_wr=0.
  - mem_addr = base + 2*k, k = 0..BLOCK_WORDS-1, from an issue counter.
  - Owner grant=1. After the last issue -> DRAIN.
- DRAIN: mem_enable=0; owner grant stays 1.
- Read returns (ISSUE and DRAIN):
  - Each mem_data_valid forwards mem_data_out to the owner's data port with data_valid=1 and word = return counter, combinationally in the same cycle. The return counter then increments.
  - The non-owner's data_valid stays 0.
  - On the BLOCK_WORDS-th return the owner's done pulses in the same cycle as the last word. grant drops next cycle; next state IDLE.
- Read timing (BLOCK_WORDS=8, MEM_LAT=4): request seen in cycle 0; issues in cycles 1–8; returns in cycles 5–12; done in cycle 12; next arbitration in cycle 13.
- mem_data_valid outside ISSUE/DRAIN is ignored.
- Request handling:
  - A request deassertion mid-transaction is ignored; the transaction completes.
  - Requests are never queued; the requester keeps req high.
- Simultaneous events:
  - A D write and an I read arriving together: D wins.
  - The losing request stays pending and is served at the next IDLE.
- Asynchronous reset mid-transaction: immediate return to the reset state, then FLUSH.
- Widths and counters:
  - Address arithmetic is modulo 2^ADDR_WIDTH.
  - The base is block-aligned, so no wrap occurs inside a block.
  - Counters are log2(BLOCK_WORDS) bits wide; the terminal count is detected explicitly, not by overflow.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - A last-served flag (reset = I) alternates priority when i_req and d_req are both pending in IDLE. The requester not served last wins.
  - A write counts as a D service.
- Not defined: fixed D-over-I priority; I may starve under continuous D traffic.

Test Plan:
- I read only, i_addr=0x1236 -> mem_addr 0x1230..0x123E in cycles 1–8; i_data_valid cycles 5–12 with i_word 0..7 matching mem contents; i_done in cycle 12; d_* outputs stay 0.
- D write, d_addr=0x0041, d_wdata=0xBEEF -> next cycle mem_enable=1, mem_wr=1, mem_addr=0x0040, d_done=1; a subsequent D read of 0x0040 returns word0=0xBEEF.
- i_req and d_req (read) asserted together -> D block served fully first, then I issue starts the cycle after d_done. With ARB_ROUND_ROBIN_EN and flag reset to I: D first, then the second simultaneous pair serves I first.
- d_req dropped in cycle 3 of ISSUE -> all 8 issues and returns still occur; d_done pulses once.
- rst_n low in cycle 6 of a read, released -> all outputs 0; no grant for MEM_LAT cycles; stray mem_data_valid pulses never reach i_data_valid/d_data_valid.
- Back-to-back D write then D read at the same address, with I pending -> write, read, then I read in order (fixed priority); no cycle with mem_enable asserted for two owners.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the multicycle main memory between I-cache fills and D-cache fills/writes; ARB_ROUND_ROBIN_EN selects alternating priority.
// A decision in IDLE cycle t starts memory traffic in t+1; block reads complete MEM_LAT+BLOCK_WORDS cycles later, writes in one.
// Requesters hold req until done; nothing is queued, and losers wait for the next IDLE cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_req,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    output logic                           i_grant,
    output logic [15:0]                    i_data,
    output logic                           i_data_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] i_word,
    output logic                           i_done,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_WIDTH-1:0]          d_addr,
    input  logic [15:0]                    d_wdata,
    output logic                           d_grant,
    output logic [15:0]                    d_data,
    output logic                           d_data_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] d_word,
    output logic                           d_done,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [15:0]                    mem_data_in,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid
);
    localparam int CW = $clog2(BLOCK_WORDS);
    localparam int FW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0]         LAST_WORD  = CW'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

    typedef enum logic [2:0] {FLUSH, IDLE, WRITE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [FW-1:0]         flush_cnt;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         ret_cnt;
    logic                  owner_d;
    logic                  wr_done;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] pick_base;
    logic [CW:0]           next_off;
    logic                  pick_d;
    logic                  pick_i;
    logic                  ret_fire;
    logic                  ret_last;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    // On contention the side not served last wins; a lone requester always wins.
    assign pick_d = d_req & (~i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif
    assign pick_i    = i_req & ~pick_d;
    assign pick_base = (pick_d ? d_addr : i_addr) & ALIGN_MASK;
    assign next_off  = {issue_cnt + CW'(1), 1'b0};

    // Returns only count while a read is in flight; stale or stray valids elsewhere are dropped.
    assign ret_fire = mem_data_valid & ((state == ISSUE) | (state == DRAIN));
    assign ret_last = ret_fire & (ret_cnt == LAST_WORD);

    assign i_data_valid = ret_fire & ~owner_d;
    assign i_data       = i_data_valid ? mem_data_out : '0;
    assign i_word       = i_data_valid ? ret_cnt : '0;
    assign i_done       = ret_last & ~owner_d;
    assign d_data_valid = ret_fire & owner_d;
    assign d_data       = d_data_valid ? mem_data_out : '0;
    assign d_word       = d_data_valid ? ret_cnt : '0;
    assign d_done       = (ret_last & owner_d) | wr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FLUSH;
            flush_cnt   <= FW'(MEM_LAT);
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            owner_d     <= 1'b0;
            wr_done     <= 1'b0;
            base        <= '0;
            i_grant     <= 1'b0;
            d_grant     <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_cnt == '0) state <= IDLE;
                    else                 flush_cnt <= flush_cnt - FW'(1);
                end
                IDLE: begin
                    if (pick_d && d_wr) begin
                        state       <= WRITE;
                        mem_enable  <= 1'b1;
                        mem_wr      <= 1'b1;
                        mem_addr    <= {d_addr[ADDR_WIDTH-1:1], 1'b0};
                        mem_data_in <= d_wdata;
                        d_grant     <= 1'b1;
                        wr_done     <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d      <= 1'b1;
`endif
                    end else if (pick_d || pick_i) begin
                        state      <= ISSUE;
                        owner_d    <= pick_d;
                        base       <= pick_base;
                        mem_addr   <= pick_base;
                        mem_enable <= 1'b1;
                        mem_wr     <= 1'b0;
                        issue_cnt  <= '0;
                        ret_cnt    <= '0;
                        d_grant    <= pick_d;
                        i_grant    <= pick_i;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d     <= pick_d;
`endif
                    end
                end
                WRITE: begin
                    state       <= IDLE;
                    mem_enable  <= 1'b0;
                    mem_wr      <= 1'b0;
                    mem_addr    <= '0;
                    mem_data_in <= '0;
                    d_grant     <= 1'b0;
                    wr_done     <= 1'b0;
                end
                ISSUE: begin
                    if (issue_cnt == LAST_WORD) begin
                        state      <= DRAIN;
                        mem_enable <= 1'b0;
                        mem_addr   <= '0;
                    end else begin
                        issue_cnt <= issue_cnt + CW'(1);
                        mem_addr  <= base | ADDR_WIDTH'(next_off);
                    end
                end
                default: ;
            endcase

            // Placed after the case so block completion overrides any state update above.
            if (ret_fire) begin
                ret_cnt <= ret_cnt + CW'(1);
                if (ret_last) begin
                    state      <= IDLE;
                    i_grant    <= 1'b0;
                    d_grant    <= 1'b0;
                    mem_enable <= 1'b0;
                    mem_addr   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model and a golden image of memory contents.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int BW = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done;
    logic [15:0] i_data, d_data;
    logic [2:0]  i_word, d_word;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        stray = 1'b0;

    logic [15:0] mem  [0:32767];
    logic [15:0] gold [0:32767];
    logic [LAT-1:0] pv = '0;
    logic [15:0] pd [LAT];

    int checks = 0;
    int passed = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
        .i_data_valid(i_data_valid), .i_word(i_word), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
        .d_word(d_word), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;
        pv    <= {pv[LAT-2:0], mem_enable & ~mem_wr};
        pd[0] <= mem[mem_addr[15:1]];
        for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
    end
    assign mem_data_valid = pv[LAT-1] | stray;
    assign mem_data_out   = pd[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the IDLE cycle that samples the request (cycle 0); runs through the done cycle (12).
    task automatic expect_block(input bit own_d, input logic [15:0] addr, input int drop_at);
        logic [15:0] base;
        logic g_own, g_oth, v_own, v_oth, dn_own, dn_oth;
        logic [15:0] dat;
        logic [2:0]  wrd;
        base = addr & 16'hFFF0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == drop_at) begin
                if (own_d) d_req = 1'b0; else i_req = 1'b0;
                #1;
            end
            g_own  = own_d ? d_grant : i_grant;       g_oth  = own_d ? i_grant : d_grant;
            v_own  = own_d ? d_data_valid : i_data_valid;
            v_oth  = own_d ? i_data_valid : d_data_valid;
            dn_own = own_d ? d_done : i_done;         dn_oth = own_d ? i_done : d_done;
            dat    = own_d ? d_data : i_data;         wrd    = own_d ? d_word : i_word;
            check($sformatf("%s c%0d en", own_d ? "d" : "i", n), mem_enable, n <= 8);
            if (n <= 8) begin
                check($sformatf("c%0d addr", n), mem_addr, base + 16'(2 * (n - 1)));
                check($sformatf("c%0d wr", n), mem_wr, 0);
            end
            check($sformatf("c%0d grant", n), g_own, 1);
            check($sformatf("c%0d other grant", n), g_oth, 0);
            check($sformatf("c%0d valid", n), v_own, n >= 5);
            check($sformatf("c%0d other valid", n), v_oth, 0);
            if (n >= 5) begin
                check($sformatf("c%0d word", n), wrd, n - 5);
                check($sformatf("c%0d data", n), dat, gold[(base >> 1) + 16'(n - 5)]);
            end
            check($sformatf("c%0d done", n), dn_own, n == 12);
            check($sformatf("c%0d other done", n), dn_oth, 0);
            if (n == 12) begin
                if (own_d) d_req = 1'b0; else i_req = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grants"}, {i_grant, d_grant}, 0);
        check({tag, " valids"}, {i_data_valid, d_data_valid}, 0);
        check({tag, " dones"}, {i_done, d_done}, 0);
        check({tag, " mem ctl"}, {mem_enable, mem_wr}, 0);
        check({tag, " mem addr"}, mem_addr, 0);
        check({tag, " mem din"}, mem_data_in, 0);
        check({tag, " data"}, {i_data, d_data}, 0);
        check({tag, " words"}, {i_word, d_word}, 0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] wdat, input bit i_pend);
        d_req = 1'b1; d_wr = 1'b1; d_addr = addr; d_wdata = wdat;
        gold[addr[15:1]] = wdat;
        step();
        check("wr en", {mem_enable, mem_wr}, 2'b11);
        check("wr addr", mem_addr, {addr[15:1], 1'b0});
        check("wr din", mem_data_in, wdat);
        check("wr grant/done", {d_grant, d_done}, 2'b11);
        check("wr i idle", {i_grant, i_data_valid, d_data_valid}, 0);
        if (i_pend) check("wr i pending", i_req, 1);
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            mem[a]  = 16'(a) ^ 16'h5A3C;
            gold[a] = 16'(a) ^ 16'h5A3C;
        end
        #2;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) step();

        // I read alone; address offset within block is discarded
        i_req = 1'b1; i_addr = 16'h1236;
        expect_block(1'b0, 16'h1236, 0);
        step();

        // Simultaneous reads: D wins first in both priority modes
        i_req = 1'b1; i_addr = 16'h0300; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0480;
        expect_block(1'b1, 16'h0480, 0);
        step();
        check("pair gap", {i_grant, d_grant}, 0);
        expect_block(1'b0, 16'h0300, 0);
        step();

        // Second simultaneous pair: priority mode decides
        i_req = 1'b1; i_addr = 16'h0610; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h07A0;
`ifdef ARB_ROUND_ROBIN_EN
        expect_block(1'b0, 16'h0610, 0);
        step();
        expect_block(1'b1, 16'h07A0, 0);
`else
        expect_block(1'b1, 16'h07A0, 0);
        step();
        expect_block(1'b0, 16'h0610, 0);
`endif
        step();

        // Write then read back the same block
        do_write(16'h0041, 16'hBEEF, 1'b0);
        d_req = 1'b0; d_wr = 1'b0;
        step();
        check("post wr", {mem_enable, d_grant, d_done}, 0);
        d_req = 1'b1; d_addr = 16'h0040;
        expect_block(1'b1, 16'h0040, 0);
        step();

        // D read with request dropped in cycle 3
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0A00;
        expect_block(1'b1, 16'h0A00, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("drop tail%0d", k), {d_done, d_grant, mem_enable}, 0);
        end

        // Reset in cycle 6 of an I read, then stray valids during flush
        i_req = 1'b1; i_addr = 16'h2000;
        for (int k = 1; k <= 6; k++) step();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid rst");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            stray = 1'b1;
            #1;
            check($sformatf("flush%0d grant", k), {i_grant, d_grant}, 0);
            check($sformatf("flush%0d valid", k), {i_data_valid, d_data_valid}, 0);
            step();
        end
        stray = 1'b0;
        check("flush end grant", {i_grant, d_grant}, 0);
        expect_block(1'b0, 16'h2000, 0);
        step();

        // Write then read by D with I pending throughout
        i_req = 1'b1; i_addr = 16'h0500;
        do_write(16'h0100, 16'h1234, 1'b1);
        d_wr = 1'b0;
        step();
        check("b2b gap", {i_grant, d_grant, d_done, mem_enable}, 0);
`ifdef ARB_ROUND_ROBIN_EN
        expect_block(1'b0, 16'h0500, 0);
        step();
        expect_block(1'b1, 16'h0100, 0);
`else
        expect_block(1'b1, 16'h0100, 0);
        step();
        expect_block(1'b0, 16'h0500, 0);
`endif
        step();
        check("final idle", {i_grant, d_grant, mem_enable}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
